// File: rtl/multicycle_controller_if.sv
// Instruction/data memory handshake bundle for multicycle_controller.
interface multicycle_controller_if;
    logic        imem_req;
    logic        imem_ready;
    logic [18:0] imem_rdata;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ready;

    modport master (output imem_req, dmem_req, dmem_we,
                    input  imem_ready, imem_rdata, dmem_ready);
    modport slave  (input  imem_req, dmem_req, dmem_we,
                    output imem_ready, imem_rdata, dmem_ready);
endinterface

// File: rtl/multicycle_controller.sv
// FETCH/DECODE/EXEC/MEM/WB sequencer for the 19-bit datapath with return-stack traps.
// Optional memory watchdog enabled by defining MEM_TIMEOUT_EN.
module multicycle_controller #(
    parameter int STACK_DEPTH    = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    multicycle_controller_if.master  bus,
    output logic [18:0]              ir_o,
    input  logic                     zero_i,
    input  logic                     carry_i,
    output logic                     pc_write_o,
    output logic [1:0]               pc_src_o,
    output logic [2:0]               acode_o,
    output logic [1:0]               scode_o,
    output logic                     is_shift_o,
    output logic                     alu_src_o,
    output logic                     mem_or_alu_o,
    output logic                     reg2_read_source_o,
    output logic                     update_z_c_o,
    output logic                     reg_write_o,
    output logic                     stack_push_o,
    output logic                     stack_pop_o,
    output logic                     halted_o,
    output logic [2:0]               err_o
);
    localparam int CW = $clog2(STACK_DEPTH + 1);

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_e;
    typedef enum logic [3:0] {C_ALU, C_SHIFT, C_LOAD, C_STORE, C_BR, C_JMP,
                              C_JSB, C_RET, C_HLT, C_ILL} cls_e;

    state_e      state_q, state_d;
    logic [18:0] ir_q, ir_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]  err_q, err_d;
    cls_e        cls;
    logic        taken;

`ifdef MEM_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_q, tmo_d;
    logic          waiting;
`endif

    always_comb begin
        cls = C_ILL;
        if (&ir_q)                          cls = C_HLT;
        else if (ir_q[18:17] == 2'b00)      cls = C_ALU;
        else if (ir_q[18:17] == 2'b01)      cls = C_ALU;
        else if (ir_q[18:16] == 3'b110)     cls = C_SHIFT;
        else if (ir_q[18:16] == 3'b100)     cls = (ir_q[15:14] == 2'b00) ? C_LOAD :
                                                  (ir_q[15:14] == 2'b01) ? C_STORE : C_ILL;
        else if (ir_q[18:16] == 3'b101)     cls = C_BR;
        else if (ir_q[18:15] == 4'b1110)    cls = ir_q[14] ? C_JSB : C_JMP;
        else if (ir_q[18:13] == 6'b111100)  cls = C_RET;
    end

    always_comb begin
        case (ir_q[15:14])
            2'b00:   taken = zero_i;
            2'b01:   taken = !zero_i;
            2'b10:   taken = carry_i;
            default: taken = !carry_i;
        endcase
    end

    always_comb begin
        state_d            = state_q;
        ir_d               = ir_q;
        cnt_d              = cnt_q;
        err_d              = err_q;
        bus.imem_req       = 1'b0;
        bus.dmem_req       = 1'b0;
        bus.dmem_we        = 1'b0;
        pc_write_o         = 1'b0;
        pc_src_o           = 2'b00;
        acode_o            = 3'b000;
        scode_o            = 2'b00;
        is_shift_o         = 1'b0;
        alu_src_o          = 1'b0;
        mem_or_alu_o       = 1'b0;
        reg2_read_source_o = 1'b0;
        update_z_c_o       = 1'b0;
        reg_write_o        = 1'b0;
        stack_push_o       = 1'b0;
        stack_pop_o        = 1'b0;
        halted_o           = 1'b0;
`ifdef MEM_TIMEOUT_EN
        waiting = 1'b0;
        tmo_d   = '0;
`endif
        // Gating on rst_n keeps the combinational requests low during reset.
        if (rst_n) begin
            case (state_q)
                FETCH: begin
                    bus.imem_req = 1'b1;
                    if (bus.imem_ready) begin
                        ir_d       = bus.imem_rdata;
                        pc_write_o = 1'b1;
                        state_d    = DECODE;
                    end
                end
                DECODE: begin
                    state_d = EXEC;
                    if (cls == C_HLT) begin
                        state_d = HALT; err_d = 3'b000;
                    end else if (cls == C_ILL) begin
                        state_d = HALT; err_d = 3'b001;
                    end else if (cls == C_JSB && cnt_q == CW'(STACK_DEPTH)) begin
                        state_d = HALT; err_d = 3'b010;
                    end else if (cls == C_RET && cnt_q == '0) begin
                        state_d = HALT; err_d = 3'b011;
                    end
                end
                EXEC: begin
                    state_d = FETCH;
                    case (cls)
                        C_ALU: begin
                            acode_o = ir_q[16:14]; alu_src_o = ir_q[17];
                            update_z_c_o = 1'b1; mem_or_alu_o = 1'b1; state_d = WB;
                        end
                        C_SHIFT: begin
                            is_shift_o = 1'b1; scode_o = ir_q[15:14];
                            update_z_c_o = 1'b1; mem_or_alu_o = 1'b1; state_d = WB;
                        end
                        C_LOAD, C_STORE: begin
                            alu_src_o = 1'b1; reg2_read_source_o = 1'b1; state_d = MEM;
                        end
                        C_BR: begin
                            pc_write_o = taken; pc_src_o = 2'b01;
                        end
                        C_JMP: begin
                            pc_write_o = 1'b1; pc_src_o = 2'b01;
                        end
                        C_JSB: begin
                            pc_write_o = 1'b1; pc_src_o = 2'b01;
                            stack_push_o = 1'b1; cnt_d = cnt_q + 1'b1;
                        end
                        C_RET: begin
                            pc_write_o = 1'b1; pc_src_o = 2'b10;
                            stack_pop_o = 1'b1; cnt_d = cnt_q - 1'b1;
                        end
                        default: state_d = HALT;
                    endcase
                end
                MEM: begin
                    bus.dmem_req       = 1'b1;
                    bus.dmem_we        = (cls == C_STORE);
                    alu_src_o          = 1'b1;
                    reg2_read_source_o = 1'b1;
                    if (bus.dmem_ready) state_d = (cls == C_LOAD) ? WB : FETCH;
                end
                WB: begin
                    reg_write_o = 1'b1;
                    state_d     = FETCH;
                    if (cls == C_ALU) begin
                        acode_o = ir_q[16:14]; alu_src_o = ir_q[17]; mem_or_alu_o = 1'b1;
                    end else if (cls == C_SHIFT) begin
                        is_shift_o = 1'b1; scode_o = ir_q[15:14]; mem_or_alu_o = 1'b1;
                    end
                end
                HALT:    halted_o = 1'b1;
                default: state_d = HALT;
            endcase
`ifdef MEM_TIMEOUT_EN
            waiting = (state_q == FETCH && !bus.imem_ready) ||
                      (state_q == MEM   && !bus.dmem_ready);
            if (waiting) begin
                tmo_d = tmo_q + 1'b1;
                if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_d = HALT; err_d = 3'b100;
                end
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
            ir_q    <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
`ifdef MEM_TIMEOUT_EN
            tmo_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`ifdef MEM_TIMEOUT_EN
            tmo_q   <= tmo_d;
`endif
        end
    end

    assign ir_o  = ir_q;
    assign err_o = err_q;
endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench: stimulus queues expected control events, a monitor pops and compares them.
module tb_multicycle_controller;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic zero = 1'b0, carry = 1'b0;
    logic [18:0] ir;
    logic pc_write, is_shift, alu_src, mem_or_alu, reg2, uzc, reg_write, push, pop, halted;
    logic [1:0] pc_src, scode;
    logic [2:0] acode, err;

    multicycle_controller_if bus();

    multicycle_controller #(.STACK_DEPTH(8), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .ir_o(ir), .zero_i(zero), .carry_i(carry),
        .pc_write_o(pc_write), .pc_src_o(pc_src), .acode_o(acode), .scode_o(scode),
        .is_shift_o(is_shift), .alu_src_o(alu_src), .mem_or_alu_o(mem_or_alu),
        .reg2_read_source_o(reg2), .update_z_c_o(uzc), .reg_write_o(reg_write),
        .stack_push_o(push), .stack_pop_o(pop), .halted_o(halted), .err_o(err));

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] gap;
        logic pcw; logic [1:0] pcs; logic rw, moa, uzc; logic [2:0] ac; logic [1:0] sc;
        logic sh, as, r2, push, pop, dreq, dwe, hlt; logic [2:0] err;
    } ev_t;

    ev_t         exp_q[$];
    logic [18:0] prog[$];
    int          dlats[$];
    int          checks = 0, fails = 0;

    // Memory responders: react on negedge so the handshake lands on the next posedge.
    int dcnt = 0;
    initial begin
        bus.imem_ready = 1'b0; bus.imem_rdata = '0; bus.dmem_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.imem_req && prog.size() > 0) begin
                bus.imem_ready = 1'b1; bus.imem_rdata = prog.pop_front();
            end else bus.imem_ready = 1'b0;
            if (bus.dmem_req) begin
                if (dcnt == ((dlats.size() > 0) ? dlats[0] : 0)) begin
                    bus.dmem_ready = 1'b1; dcnt = 0;
                    if (dlats.size() > 0) void'(dlats.pop_front());
                end else begin
                    bus.dmem_ready = 1'b0; dcnt++;
                end
            end else begin
                bus.dmem_ready = 1'b0; dcnt = 0;
            end
        end
    end

    // Monitor: every visible control event is compared with the head of the queue.
    initial begin
        int cyc = 0, last = 0;
        bit hseen = 0;
        ev_t a, e;
        forever begin
            @(negedge clk); #3; cyc++;
            if (!rst_n) begin
                last = cyc; hseen = 0;
            end else if (pc_write | reg_write | uzc | push | pop |
                         (bus.dmem_req & bus.dmem_ready) | (halted & !hseen)) begin
                a = '{gap: 8'(cyc - last), pcw: pc_write, pcs: pc_src, rw: reg_write,
                      moa: mem_or_alu, uzc: uzc, ac: acode, sc: scode, sh: is_shift,
                      as: alu_src, r2: reg2, push: push, pop: pop, dreq: bus.dmem_req,
                      dwe: bus.dmem_we, hlt: halted, err: err};
                last = cyc;
                if (halted) hseen = 1;
                checks++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_event got=%h exp=none", a);
                end else begin
                    e = exp_q.pop_front();
                    if (a !== e) begin
                        fails++;
                        $display("FAIL event got=%h exp=%h", a, e);
                    end
                end
            end
        end
    end

    function automatic ev_t ev0(int gap);
        ev_t e;
        e = '0; e.gap = 8'(gap);
        return e;
    endfunction

    task automatic x_fetch(int gap);
        ev_t e; e = ev0(gap); e.pcw = 1; exp_q.push_back(e);
    endtask
    task automatic x_alu(logic [2:0] ac, logic as);
        ev_t e; e = ev0(2); e.uzc = 1; e.moa = 1; e.ac = ac; e.as = as; exp_q.push_back(e);
        e = ev0(1); e.rw = 1; e.moa = 1; e.ac = ac; e.as = as; exp_q.push_back(e);
    endtask
    task automatic x_shift(logic [1:0] sc);
        ev_t e; e = ev0(2); e.uzc = 1; e.moa = 1; e.sh = 1; e.sc = sc; exp_q.push_back(e);
        e = ev0(1); e.rw = 1; e.moa = 1; e.sh = 1; e.sc = sc; exp_q.push_back(e);
    endtask
    task automatic x_mem(logic we, int lat);
        ev_t e; e = ev0(lat + 3); e.dreq = 1; e.dwe = we; e.as = 1; e.r2 = 1; exp_q.push_back(e);
        dlats.push_back(lat);
        if (!we) begin e = ev0(1); e.rw = 1; exp_q.push_back(e); end
    endtask
    task automatic x_pc(logic [1:0] src, logic ps, logic pp);
        ev_t e; e = ev0(2); e.pcw = 1; e.pcs = src; e.push = ps; e.pop = pp; exp_q.push_back(e);
    endtask
    task automatic x_halt(int gap, logic [2:0] er);
        ev_t e; e = ev0(gap); e.hlt = 1; e.err = er; exp_q.push_back(e);
    endtask

    task automatic chk(string name, int act, int expv);
        checks++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", name, act, expv);
        end
    endtask

    function automatic int any_out();
        return int'(|{bus.imem_req, bus.dmem_req, bus.dmem_we, ir, pc_write, pc_src, acode,
                      scode, is_shift, alu_src, mem_or_alu, reg2, uzc, reg_write, push, pop,
                      halted, err});
    endfunction

    task automatic begin_phase();
        @(negedge clk); rst_n = 1'b0;
        prog.delete(); dlats.delete();
        @(negedge clk);
    endtask

    task automatic run_phase();
        #4 rst_n = 1'b1;
        for (int i = 0; i < 300 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            checks++; fails++;
            $display("FAIL drain_timeout got=%0d exp=0 pending", exp_q.size());
            exp_q.delete();
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic stuck_then_reset(logic [2:0] er, logic [18:0] iw);
        repeat (5) @(negedge clk);
        chk("stuck_halted", int'(halted), 1);
        chk("stuck_err", int'(err), int'(er));
        chk("stuck_ir", int'(ir), int'(iw));
        chk("stuck_no_req", int'(bus.imem_req), 0);
        #2 rst_n = 1'b0;
        #1 chk("async_reset_outputs", any_out(), 0);
    endtask

    initial begin
        #12 chk("reset_outputs", any_out(), 0);

        // ALU reg, ALU immediate, shift
        begin_phase();
        prog = '{19'h00000, 19'h34000, 19'h68000, 19'h7FFFF};
        x_fetch(1); x_alu(3'd0, 1'b0); x_fetch(1); x_alu(3'd5, 1'b1);
        x_fetch(1); x_shift(2'd2); x_fetch(1); x_halt(2, 3'd0);
        run_phase();

        // load with 3 wait cycles, zero-wait store
        begin_phase();
        prog = '{19'h40000, 19'h44000, 19'h7FFFF};
        x_fetch(1); x_mem(1'b0, 3); x_fetch(1); x_mem(1'b1, 0); x_fetch(1); x_halt(2, 3'd0);
        run_phase();

        // branches with zero=1 carry=1: bz taken, bnz not, bc taken, bnc not, jmp
        begin_phase();
        zero = 1'b1; carry = 1'b1;
        prog = '{19'h50000, 19'h54000, 19'h58000, 19'h5C000, 19'h70000, 19'h7FFFF};
        x_fetch(1); x_pc(2'b01, 0, 0); x_fetch(1); x_fetch(3); x_pc(2'b01, 0, 0);
        x_fetch(1); x_fetch(3); x_pc(2'b01, 0, 0); x_fetch(1); x_halt(2, 3'd0);
        run_phase();

        // zero=0 carry=0: bz not taken, bnz taken
        begin_phase();
        zero = 1'b0; carry = 1'b0;
        prog = '{19'h50000, 19'h54000, 19'h7FFFF};
        x_fetch(1); x_fetch(3); x_pc(2'b01, 0, 0); x_fetch(1); x_halt(2, 3'd0);
        run_phase();

        // nine jsb: eight pushes then overflow trap
        begin_phase();
        for (int i = 0; i < 9; i++) prog.push_back(19'h74000);
        x_fetch(1);
        for (int i = 0; i < 8; i++) begin x_pc(2'b01, 1, 0); x_fetch(1); end
        x_halt(2, 3'd2);
        run_phase();

        // ret on empty stack
        begin_phase();
        prog = '{19'h78000};
        x_fetch(1); x_halt(2, 3'd3);
        run_phase();

        // jsb, ret, ret: one push, one pop, then underflow
        begin_phase();
        prog = '{19'h74000, 19'h78000, 19'h78000};
        x_fetch(1); x_pc(2'b01, 1, 0); x_fetch(1); x_pc(2'b10, 0, 1); x_fetch(1); x_halt(2, 3'd3);
        run_phase();

        // explicit halt, sticky, async reset
        begin_phase();
        prog = '{19'h7FFFF};
        x_fetch(1); x_halt(2, 3'd0);
        run_phase();
        stuck_then_reset(3'd0, 19'h7FFFF);

        // illegal 1111_01 encoding
        begin_phase();
        prog = '{19'h7A000};
        x_fetch(1); x_halt(2, 3'd1);
        run_phase();
        stuck_then_reset(3'd1, 19'h7A000);

        // illegal memory sub-op
        begin_phase();
        prog = '{19'h48000};
        x_fetch(1); x_halt(2, 3'd1);
        run_phase();

        // starved fetch
        begin_phase();
`ifdef MEM_TIMEOUT_EN
        x_halt(16, 3'd4);
`endif
        run_phase();
        repeat (25) @(negedge clk);
`ifdef MEM_TIMEOUT_EN
        chk("starve_halted", int'(halted), 1);
        chk("starve_err", int'(err), 4);
`else
        chk("starve_halted", int'(halted), 0);
        chk("starve_err", int'(err), 0);
        chk("starve_req", int'(bus.imem_req), 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
